// File: rtl/adder_pkg.sv
// Shared types and defaults for the chunked sequential adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Chunk counter width; a single-chunk adder still keeps a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/seq_adder.sv
// Sequential adder: sums WIDTH-bit operands CHUNK bits per cycle with a valid/ready handshake.
// Define SEQ_ADDER_OVF_EN to add the signed-overflow output Ovf.
module seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_adder: CHUNK must be >= 1 and divide WIDTH exactly");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;

    logic [CHUNK-1:0] a_ch, b_ch, sum_ch;
    logic             sum_co;
    logic             last_chunk;

`ifdef SEQ_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a  (a_ch),
        .b  (b_ch),
        .ci (carry_q),
        .s  (sum_ch),
        .co (sum_co)
    );

    assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
`ifdef SEQ_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Ci;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (cnt_q == CW'(k)) begin
                        s_d[k*CHUNK +: CHUNK] = sum_ch;
                    end
                end
                carry_d = sum_co;
                cnt_d   = cnt_q + CW'(1);
                if (last_chunk) begin
                    co_d    = sum_co;
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SEQ_ADDER_OVF_EN
                    // Carry into the MSB is recovered from its sum bit: c = a ^ b ^ s.
                    ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_ch[CHUNK-1] ^ sum_co;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Co        = co_q;
`ifdef SEQ_ADDER_OVF_EN
    assign Ovf       = (state_q == DONE) & ovf_q;
`endif

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: default 32/8 instance plus a 1/1 instance.
module tb_seq_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, ci, out_valid, out_ready, co;
    logic [31:0] a, b, s;
    logic        in_valid1, in_ready1, ci1, out_valid1, out_ready1, co1;
    logic [0:0]  a1, b1, s1;
`ifdef SEQ_ADDER_OVF_EN
    logic        ovf, ovf1;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic [31:0] tab_a [8] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h0000_0000, 32'h00FF_00FF, 32'hA5A5_A5A5};
    logic [31:0] tab_b [8] = '{32'h0000_0001, 32'h1111_1111, 32'h0000_0001, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h0000_0000, 32'h0001_0001, 32'h5A5A_5A5A};
    logic        tab_c [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    seq_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s),
        .Co        (co)
`ifdef SEQ_ADDER_OVF_EN
        ,
        .Ovf       (ovf)
`endif
    );

    seq_adder #(.WIDTH(1), .CHUNK(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .A         (a1),
        .B         (b1),
        .Ci        (ci1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .S         (s1),
        .Co        (co1)
`ifdef SEQ_ADDER_OVF_EN
        ,
        .Ovf       (ovf1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
        exp_t        e;
        logic [32:0] t;
        t     = {1'b0, ma} + {1'b0, mb} + {32'b0, mc};
        e.s   = t[31:0];
        e.co  = t[32];
        e.ovf = (ma[31] == mb[31]) && (t[31] != ma[31]);
        return e;
    endfunction

    // Drive one operand set at a negedge (DUT must be idle) and record its expected result.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ic);
        a        = ia;
        b        = ib;
        ci       = ic;
        in_valid = 1'b1;
        exp_q.push_back(model(ia, ib, ic));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge just after acceptance; lat = edges after acceptance until out_valid.
    task automatic await_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   lat;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (s !== 32'h0) begin errors++; $display("FAIL rst_S got %h want 0", s); end
        checks++; if (co !== 1'b0) begin errors++; $display("FAIL rst_Co got %b want 0", co); end
        checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || s1 !== 1'b0 || co1 !== 1'b0) begin
            errors++; $display("FAIL rst_w1 got rdy=%b vld=%b s=%b co=%b want 1 0 0 0", in_ready1, out_valid1, s1, co1);
        end
`ifdef SEQ_ADDER_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_Ovf got %b want 0", ovf); end
`endif
        rst_n = 1'b1;
        issue(32'h0000_00FF, 32'h0000_0001, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL first_accept in_ready got %b want 0", in_ready); end
        await_out(lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL first_latency got %0d want 4", lat); end
        e = exp_q.pop_front();
        checks++; if (s !== e.s || co !== e.co) begin errors++; $display("FAIL first_result got %h/%b want %h/%b", s, co, e.s, e.co); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t        e;
        int          lat;
        logic [31:0] va, vb;
        logic        vc;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                va = tab_a[i]; vb = tab_b[i]; vc = tab_c[i];
            end else begin
                va = $urandom; vb = $urandom; vc = 1'($urandom_range(1));
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d] got %b want 1", i, in_ready); end
            issue(va, vb, vc);
            await_out(lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 4", i, lat); end
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL basic_queue[%0d] got empty want 1 entry", i);
            end else begin
                e = exp_q.pop_front();
                checks++; if (s !== e.s) begin errors++; $display("FAIL basic_S[%0d] got %h want %h", i, s, e.s); end
                checks++; if (co !== e.co) begin errors++; $display("FAIL basic_Co[%0d] got %b want %b", i, co, e.co); end
`ifdef SEQ_ADDER_OVF_EN
                checks++; if (ovf !== e.ovf) begin errors++; $display("FAIL basic_Ovf[%0d] got %b want %b", i, ovf, e.ovf); end
`endif
            end
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL basic_release[%0d] got vld=%b rdy=%b want 0 1", i, out_valid, in_ready);
            end
`ifdef SEQ_ADDER_OVF_EN
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_Ovf_idle[%0d] got %b want 0", i, ovf); end
`endif
        end
    endtask

    task automatic test_width1();
        int   lat;
        logic xa, xb, xc;
        out_ready1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            xa = 1'(i >> 2); xb = 1'(i >> 1); xc = 1'(i);
            checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL w1_ready[%0d] got %b want 1", i, in_ready1); end
            a1 = xa; b1 = xb; ci1 = xc; in_valid1 = 1'b1;
            @(negedge clk);
            in_valid1 = 1'b0;
            a1 = ~xa; b1 = ~xb; ci1 = ~xc;
            lat = 0;
            while (out_valid1 !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat != 1) begin errors++; $display("FAIL w1_latency[%0d] got %0d want 1", i, lat); end
            checks++; if (s1 !== (xa ^ xb ^ xc)) begin errors++; $display("FAIL w1_S[%0d] got %b want %b", i, s1, xa ^ xb ^ xc); end
            checks++; if (co1 !== ((xa & xb) | (xa & xc) | (xb & xc))) begin
                errors++; $display("FAIL w1_Co[%0d] got %b want %b", i, co1, (xa & xb) | (xa & xc) | (xb & xc));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        int   seen;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %b want 1", in_ready); end
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; ci = 1'b1;
        await_out(lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
        e = exp_q.pop_front();
        checks++; if (s !== 32'h2345_6789 || co !== e.co) begin errors++; $display("FAIL bp_result got %h/%b want 23456789/%b", s, co, e.co); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = (c == 1);
            if (c == 1) begin a = 32'hFFFF_FFFF; b = 32'h1; end
            checks++; if (s !== e.s || co !== e.co || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got S=%h Co=%b vld=%b rdy=%b want %h %b 1 0", c, s, co, out_valid, in_ready, e.s, e.co);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL bp_ignored_pulse got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        await_out(lat);
        e = exp_q.pop_front();
        checks++; if (s !== 32'hFFFF_FFFE || co !== 1'b1) begin errors++; $display("FAIL rm_pre got %h/%b want fffffffe/1", s, co); end
        @(negedge clk);
        issue(32'h0102_0304, 32'h1020_3040, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        checks++; if (out_valid !== 1'b0 || s !== 32'h0 || co !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rm_cleared got vld=%b S=%h Co=%b rdy=%b want 0 0 0 1", out_valid, s, co, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rm_after got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        issue(32'h8765_4321, 32'h789A_BCDF, 1'b1);
        await_out(lat);
        e = exp_q.pop_front();
        checks++; if (lat != 4 || s !== e.s || co !== e.co) begin
            errors++; $display("FAIL rm_fresh got lat=%0d %h/%b want 4 %h/%b", lat, s, co, e.s, e.co);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   idx = 0, got = 0, acc = 0, cyc = 0;
        bit   pend = 0;
        out_ready = 1'b1;
        a = tab_a[1]; b = tab_b[1]; ci = tab_c[1];
        in_valid = 1'b1;
        while (got < 3 && cyc < 200) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_queue got empty want entry");
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (s !== e.s || co !== e.co) begin
                        errors++; $display("FAIL b2b_result[%0d] got %h/%b want %h/%b", got, s, co, e.s, e.co);
                    end
                end
                got++;
            end
            if (pend) begin
                pend = 0;
                idx++;
                if (idx < 3) begin
                    a = tab_a[idx + 5]; b = tab_b[idx + 5]; ci = tab_c[idx + 5];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(model(a, b, ci));
                pend = 1;
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got != 3 || acc != 3) begin errors++; $display("FAIL b2b_count got %0d results %0d accepts want 3 3", got, acc); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        ci         = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        ci1        = 1'b0;
        out_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_width1();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits; SHALL be >= 1.
REQ-002 Parameter CHUNK, default 8: bits added per cycle; SHALL divide WIDTH exactly; NCHUNK = WIDTH/CHUNK.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  A, B and Ci are valid.
REQ-006 Port in_ready  output  1  block can accept an operand set.
REQ-007 Port A  input  WIDTH  operand A.
REQ-008 Port B  input  WIDTH  operand B.
REQ-009 Port Ci  input  1  carry in.
REQ-010 Port out_valid  output  1  S, Co (and Ovf) hold a finished result.
REQ-011 Port out_ready  input  1  consumer takes the result.
REQ-012 Port S  output  WIDTH  sum, (A+B+Ci) mod 2^WIDTH.
REQ-013 Port Co  output  1  carry out of bit WIDTH-1.
REQ-014 Port Ovf  output  1  signed overflow; present only with SEQ_ADDER_OVF_EN.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE: on in_valid && in_ready, capture A, B and Ci, clear chunk counter, go to BUSY.
REQ-017 BUSY: each cycle add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) with the registered carry, write the result into S chunk k, update carry, increment k.
REQ-018 BUSY -> DONE after the cycle that processes chunk NCHUNK-1; Co = final carry.
REQ-019 Latency: accept on edge t; out_valid high after edge t+NCHUNK; NCHUNK=1 gives one BUSY cycle.
REQ-020 DONE: S, Co, Ovf held stable while out_ready=0; on out_ready=1 go to IDLE on the next edge.
REQ-021 in_valid is ignored in BUSY and DONE; a new operand set is accepted only in IDLE.
REQ-022 A, B and Ci are sampled only at acceptance; later input changes do not affect the result.
REQ-023 Wrap-around: overflow past 2^WIDTH-1 sets Co=1; S keeps the low WIDTH bits.

Reset
REQ-024 While rst_n=0: state=IDLE, S=0, Co=0, Ovf=0, counter=0, carry=0, out_valid=0, in_ready=1.
REQ-025 Reset asserted in BUSY or DONE abandons the operation; no partial result is ever presented.
REQ-026 First acceptance is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With SEQ_ADDER_OVF_EN defined: the Ovf port exists; Ovf = carry into MSB XOR carry out of MSB, valid in DONE, 0 elsewhere.
REQ-028 Without SEQ_ADDER_OVF_EN: no Ovf port, no overflow logic; all other behaviour is identical.

Structure
REQ-029 Package adder_pkg SHALL hold the state enum typedef (IDLE/BUSY/DONE) and the default WIDTH/CHUNK constants.
REQ-030 Sub-module chunk_adder (parameter CHUNK; ports a, b, ci, s, co; combinational ripple of full-adder cells) SHALL perform the per-cycle add.
REQ-031 The counter width is clog2(NCHUNK), minimum 1.

Verification
REQ-032 WIDTH=1, CHUNK=1, all 8 {A,B,Ci} combinations -> S = A^B^Ci, Co = majority; e.g. A=1, B=1, Ci=0 -> S=0, Co=1.
REQ-033 Defaults, A=FFFFFFFF, B=00000001, Ci=0 -> S=00000000, Co=1, out_valid rises exactly 4 edges after acceptance.
REQ-034 OVF_EN, A=7FFFFFFF, B=00000001 -> S=80000000, Co=0, Ovf=1; A=FFFFFFFF, B=FFFFFFFF -> S=FFFFFFFE, Co=1, Ovf=0.
REQ-035 Backpressure: result A=12345678 + B=11111111 (S=23456789) with out_ready=0 for 3 cycles -> S stable, in_ready=0, second in_valid pulse ignored; out_ready=1 -> IDLE next edge.
REQ-036 rst_n pulsed low in the 2nd BUSY cycle -> out_valid=0, S=0, Co=0 immediately; in_ready=1; a fresh operation completes correctly.
REQ-037 Back-to-back: in_valid held high over 3 operand sets -> each accepted only in IDLE, results in order, none dropped.
